// File: rtl/servo_slew_ctrl_pkg.sv
// ============================================================================
// servo_pkg : shared constants, types and FSM encoding for the servo command path
// Rev 1.0
// ============================================================================
`default_nettype none

package servo_pkg;

  localparam int unsigned CLK_HZ    = 50_000_000;
  localparam int unsigned POS_W     = 8;
  localparam int unsigned PW_W      = 32;
  localparam int unsigned MIN_PULSE = 50_000;
  localparam int unsigned MAX_PULSE = 100_000;
  localparam int unsigned POS_SCALE = 196;
  localparam int unsigned SLEW_STEP = 2_000;
  // Mid-scale position; the servo parks here out of reset
  localparam int unsigned CENTER    = MIN_PULSE + (2 ** (POS_W - 1)) * POS_SCALE;

  typedef logic [PW_W-1:0]  pw_t;
  typedef logic [POS_W-1:0] pos_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RAMP  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/servo_pos_to_width.sv
// ============================================================================
// servo_pos_to_width : maps a position command to a clamped pulse width in clocks
// Rev 1.0
// ============================================================================
`default_nettype none

module servo_pos_to_width #(
  parameter int unsigned POS_W     = servo_pkg::POS_W,
  parameter int unsigned PW_W      = servo_pkg::PW_W,
  parameter int unsigned MIN_PULSE = servo_pkg::MIN_PULSE,
  parameter int unsigned MAX_PULSE = servo_pkg::MAX_PULSE,
  parameter int unsigned POS_SCALE = servo_pkg::POS_SCALE
) (
  input  logic [POS_W-1:0] pos,
  output logic [PW_W-1:0]  width
);

  logic [PW_W-1:0] w_raw;

  assign w_raw = PW_W'(MIN_PULSE) + PW_W'(pos) * PW_W'(POS_SCALE);
  assign width = (w_raw > PW_W'(MAX_PULSE)) ? PW_W'(MAX_PULSE) : w_raw;

endmodule

`default_nettype wire

// File: rtl/servo_slew_ctrl.sv
// ============================================================================
// servo_slew_ctrl : accepts position commands and slews the PWM pulse width once per frame
// Rev 1.0
// ============================================================================
`default_nettype none

module servo_slew_ctrl #(
  parameter int unsigned POS_W     = servo_pkg::POS_W,
  parameter int unsigned PW_W      = servo_pkg::PW_W,
  parameter int unsigned MIN_PULSE = servo_pkg::MIN_PULSE,
  parameter int unsigned MAX_PULSE = servo_pkg::MAX_PULSE,
  parameter int unsigned POS_SCALE = servo_pkg::POS_SCALE,
  parameter int unsigned SLEW_STEP = servo_pkg::SLEW_STEP
) (
  input  logic             clock_clk,
  input  logic             reset_low,
  input  logic             cmd_valid,
  input  logic [POS_W-1:0] cmd_pos,
  output logic             cmd_ready,
  input  logic             frame_tick,
  output logic [PW_W-1:0]  pulse_width,
  output logic             at_target,
  output logic             busy
);

  import servo_pkg::*;

  localparam logic [PW_W-1:0]   c_center   = PW_W'(MIN_PULSE + (2 ** (POS_W - 1)) * POS_SCALE);
  localparam logic [PW_W-1:0]   c_step     = PW_W'(SLEW_STEP);
  localparam logic signed [PW_W:0] c_step_pos = (PW_W + 1)'(SLEW_STEP);
  localparam logic signed [PW_W:0] c_step_neg = -c_step_pos;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PW_W-1:0] r_pulse_width;
  logic [PW_W-1:0] r_target;
  logic [PW_W-1:0] r_pend_width;
  logic            r_pending;
  logic            r_at_target;
  logic            r_busy;

  logic [PW_W-1:0]   w_map_width;
  logic [PW_W-1:0]   w_eff_target;
  logic [PW_W-1:0]   w_step_width;
  logic signed [PW_W:0] w_diff;
  logic              w_accept;
  logic              w_landed;

  servo_pos_to_width #(
    .POS_W     (POS_W),
    .PW_W      (PW_W),
    .MIN_PULSE (MIN_PULSE),
    .MAX_PULSE (MAX_PULSE),
    .POS_SCALE (POS_SCALE)
  ) u_map (
    .pos   (cmd_pos),
    .width (w_map_width)
  );

  assign w_accept     = cmd_valid & ~r_pending;
  // A pending command retargets on the same tick that consumes it
  assign w_eff_target = r_pending ? r_pend_width : r_target;
  assign w_diff       = $signed({1'b0, w_eff_target}) - $signed({1'b0, r_pulse_width});
  assign w_landed     = (w_step_width == w_eff_target);

  always_comb begin
    w_step_width = w_eff_target;
    if (w_diff > c_step_pos) begin
      w_step_width = r_pulse_width + c_step;
    end else if (w_diff < c_step_neg) begin
      w_step_width = r_pulse_width - c_step;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = ARMED;
      end
      ARMED: begin
        if (frame_tick) w_state_nxt = w_landed ? IDLE : RAMP;
      end
      RAMP: begin
        // A new command during a ramp re-arms; the ramp continues from the current width
        if (w_accept)                   w_state_nxt = ARMED;
        else if (frame_tick && w_landed) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock_clk or negedge reset_low) begin
    if (!reset_low) begin
      r_state       <= IDLE;
      r_pulse_width <= c_center;
      r_target      <= c_center;
      r_pend_width  <= c_center;
      r_pending     <= 1'b0;
      r_at_target   <= 1'b1;
      r_busy        <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_at_target <= (w_state_nxt == IDLE);
      r_busy      <= (w_state_nxt != IDLE);
      if (frame_tick) begin
        r_pulse_width <= w_step_width;
        if (r_pending) r_target <= r_pend_width;
      end
      if (w_accept) begin
        r_pend_width <= w_map_width;
        r_pending    <= 1'b1;
      end else if (frame_tick) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign cmd_ready   = ~r_pending;
  assign pulse_width = r_pulse_width;
  assign at_target   = r_at_target;
  assign busy        = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_servo_slew_ctrl.sv
// ============================================================================
// tb_servo_slew_ctrl : directed self-checking bench for servo_slew_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_servo_slew_ctrl;

  logic        clock_clk  = 1'b0;
  logic        reset_low  = 1'b0;
  logic        cmd_valid  = 1'b0;
  logic [7:0]  cmd_pos    = 8'd0;
  logic        frame_tick = 1'b0;
  logic        cmd_ready;
  logic [31:0] pulse_width;
  logic        at_target;
  logic        busy;

  int checks = 0;
  int errors = 0;

  servo_slew_ctrl dut (
    .clock_clk   (clock_clk),
    .reset_low   (reset_low),
    .cmd_valid   (cmd_valid),
    .cmd_pos     (cmd_pos),
    .cmd_ready   (cmd_ready),
    .frame_tick  (frame_tick),
    .pulse_width (pulse_width),
    .at_target   (at_target),
    .busy        (busy)
  );

  always #5 clock_clk = ~clock_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock_clk);
  endtask

  task automatic do_tick();
    @(negedge clock_clk);
    frame_tick = 1'b1;
    @(negedge clock_clk);
    frame_tick = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] p);
    @(negedge clock_clk);
    cmd_valid = 1'b1;
    cmd_pos   = p;
    @(negedge clock_clk);
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock_clk);
    reset_low = 1'b0;
    repeat (3) @(negedge clock_clk);
    reset_low = 1'b1;
    @(negedge clock_clk);
  endtask

  initial begin
    int e;

    // Reset values
    do_reset();
    check("rst_pw",    pulse_width, 32'd75088);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_at",    {31'd0, at_target}, 32'd1);
    check("rst_busy",  {31'd0, busy}, 32'd0);

    // Full-scale command ramps up to the clamp-free maximum 99980
    send_cmd(8'd255);
    check("armed_ready", {31'd0, cmd_ready}, 32'd0);
    check("armed_busy",  {31'd0, busy}, 32'd1);
    check("armed_pw",    pulse_width, 32'd75088);
    for (int k = 1; k <= 13; k++) begin
      wait_cycles(20);
      do_tick();
      e = 75088 + 2000 * k;
      if (e > 99980) e = 99980;
      check("ramp_up", pulse_width, e);
      if (k == 12) check("ramp_up_busy", {31'd0, busy}, 32'd1);
    end
    check("up_at",   {31'd0, at_target}, 32'd1);
    check("up_busy", {31'd0, busy}, 32'd0);

    // Zero command ramps down to MIN_PULSE and stays there
    do_reset();
    send_cmd(8'd0);
    for (int k = 1; k <= 14; k++) begin
      wait_cycles(20);
      do_tick();
      e = 75088 - 2000 * k;
      if (e < 50000) e = 50000;
      check("ramp_dn", pulse_width, e);
    end
    check("dn_at", {31'd0, at_target}, 32'd1);

    // Back-to-back commands: second held off until the tick consumes the first
    do_reset();
    send_cmd(8'd200);
    cmd_valid = 1'b1;
    cmd_pos   = 8'd10;
    wait_cycles(3);
    check("hold_ready", {31'd0, cmd_ready}, 32'd0);
    frame_tick = 1'b1;
    @(negedge clock_clk);
    frame_tick = 1'b0;
    check("hold_pw1",    pulse_width, 32'd77088);
    check("hold_ready2", {31'd0, cmd_ready}, 32'd1);
    @(negedge clock_clk);
    cmd_valid = 1'b0;
    check("second_acc", {31'd0, cmd_ready}, 32'd0);
    for (int j = 1; j <= 13; j++) begin
      wait_cycles(5);
      do_tick();
      e = 77088 - 2000 * j;
      if (e < 51960) e = 51960;
      check("reverse", pulse_width, e);
    end
    check("rev_at", {31'd0, at_target}, 32'd1);

    // Command accepted on a tick with nothing pending waits for the next tick
    @(negedge clock_clk);
    cmd_valid  = 1'b1;
    cmd_pos    = 8'd128;
    frame_tick = 1'b1;
    @(negedge clock_clk);
    cmd_valid  = 1'b0;
    frame_tick = 1'b0;
    check("same_pw",    pulse_width, 32'd51960);
    check("same_ready", {31'd0, cmd_ready}, 32'd0);
    check("same_at",    {31'd0, at_target}, 32'd0);
    do_tick();
    check("same_next", pulse_width, 32'd53960);

    // Asynchronous reset mid-ramp with a command pending
    do_reset();
    send_cmd(8'd255);
    repeat (5) do_tick();
    check("mid_pw", pulse_width, 32'd85088);
    send_cmd(8'd0);
    check("mid_pend", {31'd0, cmd_ready}, 32'd0);
    @(posedge clock_clk);
    #2;
    reset_low = 1'b0;
    #1;
    check("async_pw",    pulse_width, 32'd75088);
    check("async_ready", {31'd0, cmd_ready}, 32'd1);
    check("async_at",    {31'd0, at_target}, 32'd1);
    @(negedge clock_clk);
    reset_low = 1'b1;
    @(negedge clock_clk);
    check("post_ready", {31'd0, cmd_ready}, 32'd1);
    do_tick();
    check("post_pw", pulse_width, 32'd75088);
    check("post_at", {31'd0, at_target}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
